// File: rtl/float_add_arbiter_if.sv
// Bundle of requester, shared-adder and result signals for float_add_arbiter.
// The slave modport is the arbiter's view; master is the surrounding system.
interface float_add_arbiter_if #(
  parameter int NUM_REQ       = 4,
  parameter int MANTISSA_SIZE = 23,
  parameter int EXPONENT_SIZE = 8,
  parameter int LATENCY       = 4
);
  localparam int FLOAT_SIZE = 1 + EXPONENT_SIZE + MANTISSA_SIZE;
  localparam int TAG_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W      = $clog2(LATENCY + 1);

  logic [NUM_REQ-1:0]            reqValid;
  logic [NUM_REQ*FLOAT_SIZE-1:0] reqA;
  logic [NUM_REQ*FLOAT_SIZE-1:0] reqB;
  logic [NUM_REQ-1:0]            reqReady;
  logic                          addCe;
  logic [FLOAT_SIZE-1:0]         addA;
  logic [FLOAT_SIZE-1:0]         addB;
  logic [FLOAT_SIZE-1:0]         addSum;
  logic                          resValid;
  logic                          resReady;
  logic [TAG_W-1:0]              resTag;
  logic [FLOAT_SIZE-1:0]         resData;
  logic [CNT_W-1:0]              inFlight;

  modport slave (
    input  reqValid, reqA, reqB, addSum, resReady,
    output reqReady, addCe, addA, addB, resValid, resTag, resData, inFlight
  );

  modport master (
    output reqValid, reqA, reqB, addSum, resReady,
    input  reqReady, addCe, addA, addB, resValid, resTag, resData, inFlight
  );
endinterface

// File: rtl/float_add_arbiter.sv
// Round-robin front end that time-shares one pipelined float adder between
// NUM_REQ requesters, tracking ownership of each result with a shadow pipeline.
module float_add_arbiter #(
  parameter int NUM_REQ       = 4,
  parameter int MANTISSA_SIZE = 23,
  parameter int EXPONENT_SIZE = 8,
  parameter int LATENCY       = 4
) (
  input logic               clk,
  input logic               resetn,
  float_add_arbiter_if.slave bus
);
  localparam int FLOAT_SIZE = 1 + EXPONENT_SIZE + MANTISSA_SIZE;
  localparam int TAG_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W      = $clog2(LATENCY + 1);

  // Handshakes: a requester transfer happens on a rising edge where
  // reqValid[i] && reqReady[i]; a result is consumed where resValid && resReady.
  // reqReady never depends on anything but reqValid, the stall and lastGrant.

  logic                   stall;
  logic                   add_ce;
  logic                   res_valid;
  logic                   res_accept;
  logic                   transfer;
  logic                   grant_found;
  logic                   grant_valid;
  logic [TAG_W-1:0]       grant_idx;
  logic [NUM_REQ-1:0]     req_ready;
  logic [FLOAT_SIZE-1:0]  op_a;
  logic [FLOAT_SIZE-1:0]  op_b;

  logic [TAG_W-1:0]       last_grant_q, last_grant_d;
  logic [LATENCY-1:0]     sh_valid_q, sh_valid_d;
  logic [TAG_W-1:0]       sh_tag_q [LATENCY];
  logic [TAG_W-1:0]       sh_tag_d [LATENCY];
  logic [CNT_W-1:0]       in_flight_q, in_flight_d;

  assign res_valid  = sh_valid_q[LATENCY-1];
  assign stall      = res_valid && !bus.resReady;
  assign add_ce     = !stall;
  assign res_accept = res_valid && bus.resReady;

  // Search upward from the requester after the last one served, wrapping.
  always_comb begin
    int               idx;
    logic [TAG_W-1:0] idx_t;
    grant_found = 1'b0;
    grant_idx   = '0;
    idx         = 0;
    idx_t       = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = int'(last_grant_q) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      idx_t = TAG_W'(idx);
      if (!grant_found && bus.reqValid[idx_t]) begin
        grant_found = 1'b1;
        grant_idx   = idx_t;
      end
    end
  end

  assign grant_valid = resetn && add_ce && grant_found;

  always_comb begin
    req_ready = '0;
    op_a      = '0;
    op_b      = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_valid && (grant_idx == TAG_W'(i))) begin
        req_ready[i] = 1'b1;
        op_a         = bus.reqA[i*FLOAT_SIZE +: FLOAT_SIZE];
        op_b         = bus.reqB[i*FLOAT_SIZE +: FLOAT_SIZE];
      end
    end
  end

  assign transfer = |(bus.reqValid & req_ready);

  // The shadow moves in lock-step with the adder, bubbles included, so a
  // stage's tag always lines up with the addSum that emerges beside it.
  always_comb begin
    sh_valid_d   = sh_valid_q;
    sh_tag_d     = sh_tag_q;
    last_grant_d = last_grant_q;
    in_flight_d  = in_flight_q;
    if (add_ce) begin
      for (int i = LATENCY - 1; i >= 1; i--) begin
        sh_valid_d[i] = sh_valid_q[i-1];
        sh_tag_d[i]   = sh_tag_q[i-1];
      end
      sh_valid_d[0] = transfer;
      sh_tag_d[0]   = grant_idx;
    end
    if (transfer) last_grant_d = grant_idx;
    case ({transfer, res_accept})
      2'b10:   in_flight_d = in_flight_q + CNT_W'(1);
      2'b01:   in_flight_d = in_flight_q - CNT_W'(1);
      default: in_flight_d = in_flight_q;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      last_grant_q <= TAG_W'(NUM_REQ - 1);
      sh_valid_q   <= '0;
      in_flight_q  <= '0;
      for (int i = 0; i < LATENCY; i++) sh_tag_q[i] <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      sh_valid_q   <= sh_valid_d;
      in_flight_q  <= in_flight_d;
      for (int i = 0; i < LATENCY; i++) sh_tag_q[i] <= sh_tag_d[i];
    end
  end

  assign bus.reqReady = req_ready;
  assign bus.addCe    = add_ce;
  assign bus.addA     = op_a;
  assign bus.addB     = op_b;
  assign bus.resValid = res_valid;
  assign bus.resTag   = sh_tag_q[LATENCY-1];
  assign bus.resData  = bus.addSum;
  assign bus.inFlight = in_flight_q;
endmodule
